// File: rtl/mem_bus_master_pkg.sv
// -----------------------------------------------------------------------------
// mem_bus_pkg
// Shared definitions for the 64-word x 64-bit asynchronous memory bus and its
// synchronous initiator (mem_bus_master).
//   MEM_DATA_W / MEM_ADDR_W / MEM_DEPTH : memory geometry
//   state_e                             : initiator bus-phase state
// -----------------------------------------------------------------------------
package mem_bus_pkg;

  localparam int MEM_DATA_W = 64;
  localparam int MEM_ADDR_W = 6;
  localparam int MEM_DEPTH  = 64;

  // IDLE   : waiting for a host request, bus quiet
  // SETUP  : address (and write data) presented ahead of the strobe
  // STROBE : MemWr/MemRd asserted for STROBE_CYC cycles
  // HOLD   : strobe released, address/data still held, response pulsed
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } state_e;

endpackage

// File: rtl/mem_bus_master_if.sv
// -----------------------------------------------------------------------------
// mem_bus_master_if
// Host request/response handshake plus the unidirectional memory-bus controls.
// The bidirectional DataBus is kept as a plain inout on the controller so the
// tri-state resolution stays on an ordinary net.
//   req_valid/req_ready/req_wr/req_addr/req_wdata : host request port
//   rsp_valid/rsp_wr/rsp_rdata                    : completion pulse + read data
//   MemWr/MemRd/Addr                              : memory strobes and address
// Modports: master = the controller, slave = host/memory side.
// -----------------------------------------------------------------------------
interface mem_bus_master_if
  import mem_bus_pkg::*;
#(
  parameter int DATA_W = MEM_DATA_W,
  parameter int ADDR_W = MEM_ADDR_W
);

  logic              req_valid;
  logic              req_ready;
  logic              req_wr;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_wr;
  logic [DATA_W-1:0] rsp_rdata;
  logic              MemWr;
  logic              MemRd;
  logic [ADDR_W-1:0] Addr;

  modport master (
    input  req_valid, req_wr, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_wr, rsp_rdata,
    output MemWr, MemRd, Addr
  );

  modport slave (
    output req_valid, req_wr, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_wr, rsp_rdata,
    input  MemWr, MemRd, Addr
  );

endinterface

// File: rtl/mem_bus_master.sv
// -----------------------------------------------------------------------------
// mem_bus_master
// Sequences single host read/write requests onto the asynchronous memory bus
// as SETUP -> STROBE (STROBE_CYC cycles) -> HOLD, so address and write data
// are stable one cycle either side of the strobe.
// Ports:
//   clk      : rising-edge clock
//   rst_n    : asynchronous active-low reset (strobes drop, bus releases at once)
//   bus      : mem_bus_master_if.master (host handshake + MemWr/MemRd/Addr)
//   DataBus  : shared bidirectional data bus, driven only during write ops
// Parameters: DATA_W, ADDR_W, STROBE_CYC (1..15)
// -----------------------------------------------------------------------------
module mem_bus_master
  import mem_bus_pkg::*;
#(
  parameter int DATA_W     = MEM_DATA_W,
  parameter int ADDR_W     = MEM_ADDR_W,
  parameter int STROBE_CYC = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  mem_bus_master_if.master   bus,
  inout  wire  [DATA_W-1:0]  DataBus
);

  localparam logic [3:0] LAST_CNT = 4'(STROBE_CYC - 1);

  state_e            state_q;
  logic [3:0]        cnt_q;
  logic              wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              oe_q;
  logic              memwr_q;
  logic              memrd_q;
  logic              rsp_valid_q;
  logic              rsp_wr_q;
  logic [DATA_W-1:0] rdata_q;

  // All bus-facing outputs are flops; each is loaded with the value it must
  // hold in the state being entered, so nothing combinational reaches the pins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      oe_q        <= 1'b0;
      memwr_q     <= 1'b0;
      memrd_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_wr_q    <= 1'b0;
      rdata_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          // req_ready is high in IDLE, so valid alone means accept
          if (bus.req_valid) begin
            state_q <= SETUP;
            wr_q    <= bus.req_wr;
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
            oe_q    <= bus.req_wr;
          end
        end
        SETUP: begin
          state_q <= STROBE;
          cnt_q   <= '0;
          memwr_q <= wr_q;
          memrd_q <= !wr_q;
        end
        STROBE: begin
          if (cnt_q == LAST_CNT) begin
            state_q     <= HOLD;
            memwr_q     <= 1'b0;
            memrd_q     <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_wr_q    <= wr_q;
            // sample while MemRd is still high, before it falls on this edge
            if (!wr_q) rdata_q <= DataBus;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        HOLD: begin
          state_q     <= IDLE;
          oe_q        <= 1'b0;
          rsp_valid_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req_ready = (state_q == IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_wr    = rsp_wr_q;
  assign bus.rsp_rdata = rdata_q;
  assign bus.MemWr     = memwr_q;
  assign bus.MemRd     = memrd_q;
  assign bus.Addr      = addr_q;

  assign DataBus = oe_q ? wdata_q : 'z;

endmodule

// File: tb/tb_mem_bus_master.sv
module tb_mem_bus_master;
  import mem_bus_pkg::*;

  localparam int S = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // main DUT (STROBE_CYC = 2) with a behavioural memory on its bus
  mem_bus_master_if #(.DATA_W(64), .ADDR_W(6)) bif ();
  wire [63:0] db;
  mem_bus_master #(.DATA_W(64), .ADDR_W(6), .STROBE_CYC(S)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(bif), .DataBus(db));

  // strobe-width variants, write-only, bus left unloaded
  mem_bus_master_if #(.DATA_W(64), .ADDR_W(6)) pif1 ();
  mem_bus_master_if #(.DATA_W(64), .ADDR_W(6)) pif4 ();
  wire [63:0] db1;
  wire [63:0] db4;
  mem_bus_master #(.DATA_W(64), .ADDR_W(6), .STROBE_CYC(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .bus(pif1), .DataBus(db1));
  mem_bus_master #(.DATA_W(64), .ADDR_W(6), .STROBE_CYC(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .bus(pif4), .DataBus(db4));

  logic [63:0] mem [MEM_DEPTH];
  assign db = bif.MemRd ? mem[bif.Addr] : 'z;
  always @(posedge clk) if (bif.MemWr) mem[bif.Addr] <= db;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // bus not driven by anyone (Z in 4-state, 0 in 2-state resolution)
  task automatic chk_rel(input string nm, input logic [63:0] v);
    n_chk++;
    if (!($isunknown(v) || v == 64'd0)) begin
      n_fail++;
      $display("FAIL %s: bus driven with %h, expected released", nm, v);
    end
  endtask

  // bus monitor: strobes exclusive, and during reads the bus carries exactly
  // the memory word (any controller drive would corrupt it)
  always @(negedge clk) begin
    if (rst_n) begin
      n_chk++;
      if (bif.MemWr && bif.MemRd) begin
        n_fail++;
        $display("FAIL strobe_excl: MemWr=%b MemRd=%b, expected never both", bif.MemWr, bif.MemRd);
      end
      if (bif.MemRd) begin
        n_chk++;
        if (db !== mem[bif.Addr]) begin
          n_fail++;
          $display("FAIL read_bus: got %h, expected %h", db, mem[bif.Addr]);
        end
      end
    end
  end

  logic [63:0] last_rd = 64'd0;

  // Called at a negedge with the DUT idle; returns at the negedge of the
  // first IDLE cycle after the op. Cycle c counts from the accept edge.
  task automatic do_op(input bit wr, input logic [5:0] a, input logic [63:0] wd,
                       input logic [63:0] exp_rd, input string nm);
    bif.req_valid = 1'b1; bif.req_wr = wr; bif.req_addr = a; bif.req_wdata = wd;
    @(posedge clk);
    #1 bif.req_valid = 1'b0;
    bif.req_addr = ~a; bif.req_wdata = ~wd; bif.req_wr = ~wr;  // must be ignored
    for (int c = 1; c <= S + 3; c++) begin
      bit strb;
      @(negedge clk);
      strb = (c >= 2) && (c <= S + 1);
      chk({nm, " MemWr"},     {63'd0, bif.MemWr},     {63'd0, wr && strb});
      chk({nm, " MemRd"},     {63'd0, bif.MemRd},     {63'd0, !wr && strb});
      chk({nm, " rsp_valid"}, {63'd0, bif.rsp_valid}, {63'd0, c == S + 2});
      chk({nm, " req_ready"}, {63'd0, bif.req_ready}, {63'd0, c == S + 3});
      chk({nm, " Addr"},      {58'd0, bif.Addr},      {58'd0, a});
      if (wr && c <= S + 2) chk({nm, " DataBus"}, db, wd);
      else if (!strb)       chk_rel({nm, " DataBus"}, db);
      if (c == S + 2) begin
        chk({nm, " rsp_wr"}, {63'd0, bif.rsp_wr}, {63'd0, wr});
        if (!wr) chk({nm, " rsp_rdata"}, bif.rsp_rdata, exp_rd);
      end
      if (c == S + 3) begin
        if (!wr) last_rd = exp_rd;
        chk({nm, " rdata_hold"}, bif.rsp_rdata, last_rd);
      end
    end
  endtask

  typedef struct {
    bit          wr;
    logic [5:0]  addr;
    logic [63:0] wdata;
    logic [63:0] exp_rd;
    string       nm;
  } vec_t;

  vec_t vecs [7];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int w1, w4, l1, l4;
    for (int i = 0; i < MEM_DEPTH; i++) mem[i] = 64'h5A5A_0000_0000_0000 | 64'(i);
    bif.req_valid = 0; bif.req_wr = 0; bif.req_addr = '0; bif.req_wdata = '0;
    pif1.req_valid = 0; pif1.req_wr = 0; pif1.req_addr = '0; pif1.req_wdata = '0;
    pif4.req_valid = 0; pif4.req_wr = 0; pif4.req_addr = '0; pif4.req_wdata = '0;

    vecs[0] = '{1'b1, 6'h05, 64'hDEADBEEF_CAFEF00D, 64'h0, "wr05"};
    vecs[1] = '{1'b0, 6'h05, 64'h0, 64'hDEADBEEF_CAFEF00D, "rd05"};
    vecs[2] = '{1'b1, 6'h00, 64'h01234567_89ABCDEF, 64'h0, "wr00"};
    vecs[3] = '{1'b0, 6'h3F, 64'h0, 64'h5A5A0000_0000003F, "rd3F_init"};
    vecs[4] = '{1'b1, 6'h3F, 64'hFFFF0000_FFFF0000, 64'h0, "wr3F"};
    vecs[5] = '{1'b0, 6'h00, 64'h0, 64'h01234567_89ABCDEF, "rd00"};
    vecs[6] = '{1'b0, 6'h3F, 64'h0, 64'hFFFF0000_FFFF0000, "rd3F"};

    // reset state
    repeat (2) @(negedge clk);
    chk("rst req_ready", {63'd0, bif.req_ready}, 64'd1);
    chk("rst MemWr",     {63'd0, bif.MemWr},     64'd0);
    chk("rst MemRd",     {63'd0, bif.MemRd},     64'd0);
    chk("rst Addr",      {58'd0, bif.Addr},      64'd0);
    chk("rst rsp_valid", {63'd0, bif.rsp_valid}, 64'd0);
    chk("rst rsp_wr",    {63'd0, bif.rsp_wr},    64'd0);
    chk("rst rsp_rdata", bif.rsp_rdata,          64'd0);
    chk_rel("rst DataBus", db);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++)
      do_op(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rd, vecs[i].nm);

    // back-to-back: req_valid held high across a write then a read of 0x3F
    bif.req_valid = 1; bif.req_wr = 1; bif.req_addr = 6'h3F; bif.req_wdata = 64'h1;
    @(posedge clk);
    #1 bif.req_wr = 0; bif.req_wdata = 64'h0;
    for (int c = 1; c <= S + 3; c++) begin
      @(negedge clk);
      chk("b2b wr req_ready", {63'd0, bif.req_ready}, {63'd0, c == S + 3});
      if (c == S + 2) chk("b2b wr rsp", {62'd0, bif.rsp_valid, bif.rsp_wr}, 64'd3);
    end
    @(posedge clk);
    #1 bif.req_valid = 0;
    for (int c = 1; c <= S + 2; c++) begin
      @(negedge clk);
      chk("b2b rd req_ready", {63'd0, bif.req_ready}, 64'd0);
      chk("b2b rd rsp_valid", {63'd0, bif.rsp_valid}, {63'd0, c == S + 2});
      if (c == S + 2) begin
        chk("b2b rd rsp_wr", {63'd0, bif.rsp_wr}, 64'd0);
        chk("b2b rd rdata", bif.rsp_rdata, 64'h1);
      end
    end
    @(negedge clk);
    last_rd = 64'h1;

    // reset during the second STROBE cycle of a write
    bif.req_valid = 1; bif.req_wr = 1; bif.req_addr = 6'h10; bif.req_wdata = 64'h11112222_33334444;
    @(posedge clk);
    #1 bif.req_valid = 0;
    repeat (3) @(negedge clk);
    chk("mid MemWr before rst", {63'd0, bif.MemWr}, 64'd1);
    chk("mid DataBus before rst", db, 64'h11112222_33334444);
    #1 rst_n = 1'b0;
    #1;
    chk("mid MemWr after rst", {63'd0, bif.MemWr}, 64'd0);
    chk_rel("mid DataBus after rst", db);
    chk("mid req_ready after rst", {63'd0, bif.req_ready}, 64'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("post_rst rsp_valid", {63'd0, bif.rsp_valid}, 64'd0);
      chk("post_rst MemWr", {63'd0, bif.MemWr}, 64'd0);
    end
    last_rd = 64'd0;
    do_op(1'b0, 6'h05, 64'h0, 64'hDEADBEEF_CAFEF00D, "post_rst rd05");

    // strobe width and latency for STROBE_CYC = 1 and 4
    pif1.req_valid = 1; pif1.req_wr = 1; pif1.req_addr = 6'h2A; pif1.req_wdata = 64'h77;
    pif4.req_valid = 1; pif4.req_wr = 1; pif4.req_addr = 6'h2A; pif4.req_wdata = 64'h77;
    @(posedge clk);
    #1 pif1.req_valid = 0; pif4.req_valid = 0;
    w1 = 0; w4 = 0; l1 = 0; l4 = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (pif1.MemWr) w1++;
      if (pif4.MemWr) w4++;
      if (pif1.rsp_valid && l1 == 0) l1 = c;
      if (pif4.rsp_valid && l4 == 0) l4 = c;
    end
    chk("strobe_cyc1 width",   64'(w1), 64'd1);
    chk("strobe_cyc1 latency", 64'(l1), 64'd3);
    chk("strobe_cyc4 width",   64'(w4), 64'd4);
    chk("strobe_cyc4 latency", 64'(l4), 64'd6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
